sm_board_debug: RTL

Parametrised board-level debug controller between the board clock/buttons and the schoolMIPS core. Generates the core clock in free-run or single-step mode from a programmable divider and debounces two raw push-buttons. Lets the user browse any register and any slice of its value on a generic-width LED bank. Replaces per-board hard-wired divider/LED glue.

---
 rtl/sm_board_debug.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sm_board_debug.sv
// Board-level debug controller: cpu_clk generation (free-run or single-step),
// push-button debouncing, and register/page browsing on an LED bank.
module sm_board_debug #(
  parameter int unsigned DIV_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LED_WIDTH       = 8,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RESET_ADDR      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode_run,
  input  logic                      key_step,
  input  logic                      key_sel,
  input  logic [DIV_WIDTH-1:0]      devide,
  output logic                      cpu_clk,
  output logic [REG_ADDR_WIDTH-1:0] regAddr,
  input  logic [DATA_WIDTH-1:0]     regData,
  output logic [LED_WIDTH-1:0]      led
);

  localparam int unsigned SLICE_W = LED_WIDTH - 1;
  localparam int unsigned PAGES   = (DATA_WIDTH + SLICE_W - 1) / SLICE_W;
  localparam int unsigned PAGE_W  = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned EXT_W   = PAGES * SLICE_W;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned NKEYS   = 2;
  localparam int unsigned K_STEP  = 0;
  localparam int unsigned K_SEL   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP_HI = 2'd2
  } state_e;

  // Synchronisers: bit 0 = step, bit 1 = sel, bit 2 = mode_run; idle level is 1
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {mode_run, key_sel, key_step};
      sync2_q <= sync1_q;
    end
  end

  logic run_s;
  assign run_s = sync2_q[2];

  // Debouncers: level changes only after DEBOUNCE_CYCLES of disagreement
  logic [NKEYS-1:0] key_db_q, key_db_d;
  logic [DB_W-1:0]  db_cnt_q [NKEYS];
  logic [DB_W-1:0]  db_cnt_d [NKEYS];
  logic [NKEYS-1:0] press_c;

  always_comb begin
    key_db_d = key_db_q;
    for (int k = 0; k < NKEYS; k++) begin
      db_cnt_d[k] = db_cnt_q[k];
      if (sync2_q[k] == key_db_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_db_d[k] = sync2_q[k];
        db_cnt_d[k] = '0;
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
      end
    end
    press_c = key_db_q & ~key_db_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db_q <= '1;
      for (int k = 0; k < NKEYS; k++) db_cnt_q[k] <= '0;
    end else begin
      key_db_q <= key_db_d;
      for (int k = 0; k < NKEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
    end
  end

  // Divider: cnt above a freshly lowered devide also counts as terminal
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 terminal_c;
  logic                 cpu_clk_q;
  state_e               state_q;

  assign terminal_c = (cnt_q >= devide);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cpu_clk_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cpu_clk_q <= 1'b0;
          cnt_q     <= '0;
          if (run_s) begin
            state_q <= RUN;
          end else if (press_c[K_STEP]) begin
            state_q   <= STEP_HI;
            cpu_clk_q <= 1'b1;
          end
        end
        RUN: begin
          cnt_q <= terminal_c ? '0 : cnt_q + DIV_WIDTH'(1);
          if (terminal_c) begin
            if (!run_s) begin
              cpu_clk_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              cpu_clk_q <= ~cpu_clk_q;
            end
          end
        end
        STEP_HI: begin
          cnt_q <= terminal_c ? '0 : cnt_q + DIV_WIDTH'(1);
          if (terminal_c) begin
            cpu_clk_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          cpu_clk_q <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  // Page/register browsing: sel steps through pages, then to the next register
  logic [PAGE_W-1:0]         page_q, page_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;

  always_comb begin
    page_d     = page_q;
    reg_addr_d = reg_addr_q;
    if (press_c[K_SEL]) begin
      if (page_q == PAGE_W'(PAGES - 1)) begin
        page_d     = '0;
        reg_addr_d = reg_addr_q + REG_ADDR_WIDTH'(1);
      end else begin
        page_d = page_q + PAGE_W'(1);
      end
    end
  end

  // LED bank: bit 0 mirrors cpu_clk, upper bits show the selected slice
  logic [EXT_W-1:0]     data_ext;
  logic [SLICE_W-1:0]   slice_c;
  logic [LED_WIDTH-1:0] led_q, led_d;

  always_comb begin
    data_ext = EXT_W'(regData);
    slice_c  = SLICE_W'(data_ext >> (32'(page_q) * SLICE_W));
    led_d    = {slice_c, cpu_clk_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q     <= '0;
      reg_addr_q <= REG_ADDR_WIDTH'(RESET_ADDR);
      led_q      <= '0;
    end else begin
      page_q     <= page_d;
      reg_addr_q <= reg_addr_d;
      led_q      <= led_d;
    end
  end

  assign cpu_clk = cpu_clk_q;
  assign regAddr = reg_addr_q;
  assign led     = led_q;

endmodule
